// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// spart_pkg : shared types and constants for the SPART serial I/O stage
// Rev 1.0
// ============================================================================
package spart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int ST_RXV  = 15;
    localparam int ST_OVR  = 14;
    localparam int ST_FERR = 13;
    localparam int ST_TXF  = 12;
    localparam int ST_TXE  = 11;

    localparam logic IDLE_LINE = 1'b1;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_tx_fifo.sv
`default_nettype none
// ============================================================================
// spart_tx_fifo : TX_DEPTH x 8 transmit queue with full/empty flags
// Rev 1.0
// ============================================================================
module spart_tx_fifo #(
    parameter int TX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(TX_DEPTH);

    logic [7:0]  mem_q [TX_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_en;
    logic        pop_en;

    // Extra MSB on each pointer separates the full and empty cases.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule : spart_tx_fifo
`default_nettype wire

// File: rtl/spart_io.sv
`default_nettype none
// ============================================================================
// spart_io : 8N1 serial port stage - TX queue + serializer, RX deserializer
// Rev 1.0
// ============================================================================
module spart_io
    import spart_pkg::*;
#(
    parameter int BAUD_DIV = 5208,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_byte,
    input  logic        tx_wr,
    input  logic        rx_rd,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic        txd,
    input  logic        rxd
);

    localparam logic [15:0] c_baud_last = 16'(BAUD_DIV - 1);
    localparam logic [15:0] c_half_last = 16'(BAUD_DIV / 2 - 1);

    logic       fifo_pop;
    logic [7:0] fifo_data;
    logic       fifo_full;
    logic       fifo_empty;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    rx_state_t   rx_state_q, rx_state_d;
    logic [1:0]  rx_sync_q, rx_sync_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_s;

    spart_tx_fifo #(
        .TX_DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_wr),
        .push_data (tx_byte),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign stall = tx_wr & fifo_full;
    assign txd   = txd_q;
    assign rx_s  = rx_sync_q[1];

    always_comb begin
        rd_data          = '0;
        rd_data[ST_RXV]  = rx_valid_q;
        rd_data[ST_OVR]  = overrun_q;
        rd_data[ST_FERR] = frame_err_q;
        rd_data[ST_TXF]  = fifo_full;
        rd_data[ST_TXE]  = fifo_empty && (tx_state_q == TX_IDLE);
        rd_data[7:0]     = rx_byte_q;
    end

    // Transmit serializer: every state lasts c_baud_last+1 cycles.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_data;
                    tx_cnt_d   = c_baud_last;
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = c_baud_last;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = c_baud_last;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = IDLE_LINE;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // A read clears the sticky flags unless a stop-bit event re-sets them this cycle.
    always_comb begin
        rx_sync_d   = {rx_sync_q[0], rxd};
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rx_valid_q & ~rx_rd;
        overrun_d   = overrun_q & ~rx_rd;
        frame_err_d = frame_err_q & ~rx_rd;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s != IDLE_LINE) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = c_half_last;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s == IDLE_LINE) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = c_baud_last;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_cnt_d   = c_baud_last;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = RX_IDLE;
                    if (rx_s == IDLE_LINE) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rx_rd) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            txd_q       <= IDLE_LINE;
            rx_state_q  <= RX_IDLE;
            rx_sync_q   <= {2{IDLE_LINE}};
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            rx_state_q  <= rx_state_d;
            rx_sync_q   <= rx_sync_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule : spart_io
`default_nettype wire

// File: tb/tb_spart_io.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_spart_io : directed self-checking bench for spart_io (BAUD_DIV = 4)
// Rev 1.0
// ============================================================================
module tb_spart_io;

    localparam int BAUD = 4;

    localparam logic [1:0] K_FRAME = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_GLTCH = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  data;
        logic        stop;
        logic        rd;
        logic [15:0] exp;
    } rx_vec_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  tx_byte = 8'h00;
    logic        tx_wr   = 1'b0;
    logic        rx_rd   = 1'b0;
    logic        rxd     = 1'b1;
    logic [15:0] rd_data;
    logic        stall;
    logic        txd;

    int checks = 0;
    int errors = 0;

    rx_vec_t vecs [9];

    spart_io #(
        .BAUD_DIV (BAUD),
        .TX_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_byte (tx_byte),
        .tx_wr   (tx_wr),
        .rx_rd   (rx_rd),
        .rd_data (rd_data),
        .stall   (stall),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called on the negedge right after the pop edge; ends on the negedge 40 cycles later.
    task automatic check_frame(input logic [7:0] b, input logic chk_busy);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * BAUD; k++) begin
            check($sformatf("txd byte %h cycle %0d", b, k), {15'd0, txd}, {15'd0, bits[k / BAUD]});
            if (chk_busy) begin
                check($sformatf("tx_empty busy cycle %0d", k), {15'd0, rd_data[11]}, 16'd0);
            end
            @(negedge clk);
        end
    endtask

    // Start bit driven at a negedge; the stop sample falls on the 41st posedge after it.
    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic rd);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rxd = bits[j];
            repeat (BAUD) @(negedge clk);
        end
        rxd = 1'b1;
        if (rd) rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        vecs[0] = '{K_FRAME, 8'h3C, 1'b1, 1'b0, 16'h883C};
        vecs[1] = '{K_FRAME, 8'hC3, 1'b1, 1'b0, 16'hC8C3};
        vecs[2] = '{K_READ,  8'h00, 1'b1, 1'b1, 16'h08C3};
        vecs[3] = '{K_FRAME, 8'h77, 1'b0, 1'b0, 16'h28C3};
        vecs[4] = '{K_GLTCH, 8'h00, 1'b1, 1'b0, 16'h28C3};
        vecs[5] = '{K_FRAME, 8'h55, 1'b1, 1'b0, 16'hA855};
        vecs[6] = '{K_FRAME, 8'h11, 1'b1, 1'b1, 16'h8811};
        vecs[7] = '{K_READ,  8'h00, 1'b1, 1'b1, 16'h0811};
        vecs[8] = '{K_FRAME, 8'h66, 1'b0, 1'b1, 16'h2811};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rd_data", rd_data, 16'h0800);
        check("reset txd", {15'd0, txd}, 16'd1);
        check("reset stall", {15'd0, stall}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset rd_data", rd_data, 16'h0800);

        // Reset mid-frame during data bit 3 of 8'hA5
        tx_wr = 1'b1; tx_byte = 8'hA5;
        @(negedge clk);
        tx_wr = 1'b0;
        @(negedge clk);
        repeat (3 * BAUD + 4 + 1) @(negedge clk);
        check("mid-frame txd before reset", {15'd0, txd}, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset txd", {15'd0, txd}, 16'd1);
        check("async reset rd_data", rd_data, 16'h0800);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("txd quiet after reset", 16'(bad), 16'd0);
        check("rd_data after reset", rd_data, 16'h0800);

        // Single frame 8'h5A and exact tx_empty timing
        tx_wr = 1'b1; tx_byte = 8'h5A;
        @(negedge clk);
        tx_wr = 1'b0;
        check("queued rd_data", rd_data, 16'h0000);
        check("queued txd", {15'd0, txd}, 16'd1);
        @(negedge clk);
        check_frame(8'h5A, 1'b1);
        check("tx_empty after 40 cycles", rd_data, 16'h0800);
        repeat (3) @(negedge clk);

        // Queue full, stall, back-to-back frames
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    tx_wr = 1'b1; tx_byte = 8'(i);
                    #1;
                    check($sformatf("no stall on write %0d", i), {15'd0, stall}, 16'd0);
                    @(negedge clk);
                end
                tx_wr = 1'b1; tx_byte = 8'h06;
                #1;
                check("queue full rd_data", rd_data, 16'h1000);
                n = 0;
                while (stall && n < 100) begin
                    n++;
                    @(negedge clk);
                    #1;
                end
                check("stall cycle count", 16'(n), 16'd38);
                @(negedge clk);
                tx_wr = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                for (int f = 1; f <= 6; f++) begin
                    check_frame(8'(f), 1'b0);
                    check($sformatf("idle gap after frame %0d", f), {15'd0, txd}, 16'd1);
                    @(negedge clk);
                end
            end
        join
        check("queue drained rd_data", rd_data, 16'h0800);

        // Receive-side table
        for (int v = 0; v < 9; v++) begin
            rxd = 1'b1;
            repeat (8) @(negedge clk);
            case (vecs[v].kind)
                K_FRAME: rx_frame(vecs[v].data, vecs[v].stop, vecs[v].rd);
                K_READ: begin
                    rx_rd = 1'b1;
                    @(negedge clk);
                    rx_rd = 1'b0;
                end
                default: begin
                    rxd = 1'b0;
                    @(negedge clk);
                    rxd = 1'b1;
                    repeat (10) @(negedge clk);
                end
            endcase
            check($sformatf("rx vector %0d rd_data", v), rd_data, vecs[v].exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spart_io
`default_nettype wire
